// File: rtl/shift_req_arbiter.sv
// shift_req_arbiter: round-robin share of one registered barrel shifter, tagged results via a 2-entry response FIFO.
// Optional SHIFT_ARB_PRIO_EN: requester 0 gets strict priority over the round-robin pool.
module shift_req_arbiter #(
  parameter int BUSWIDTH   = 32,
  parameter int SHIFTWIDTH = 5,
  parameter int NREQ       = 4,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*BUSWIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]            req_rotation,
  input  logic [NREQ-1:0]            req_direction,
  input  logic [NREQ*SHIFTWIDTH-1:0] req_shift,
  output logic [BUSWIDTH-1:0]        sh_data_in,
  output logic                       sh_rotation,
  output logic                       sh_direction,
  output logic [SHIFTWIDTH-1:0]      sh_shift_val,
  input  logic [BUSWIDTH-1:0]        sh_data_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [BUSWIDTH-1:0]        rsp_data,
  output logic [IDW-1:0]             rsp_id,
  output logic                       busy
);
  localparam logic [IDW:0] NQ = (IDW+1)'(NREQ);
  logic [1:0]          credits, fifo_count;
  logic [IDW-1:0]      rr_ptr, gnt_id, inflight_id, id1;
  logic [BUSWIDTH-1:0] data1;
  logic                inflight_v, issue_ok, issue, pop, rr_upd;
  logic [NREQ-1:0]     rot;
  logic [IDW:0]        off, sum;
  assign rsp_valid = fifo_count != 2'd0;
  assign pop       = rsp_valid & rsp_ready;
  assign issue_ok  = (credits != 2'd0) | pop;
  assign issue     = issue_ok & |req_valid;
  assign busy      = inflight_v | rsp_valid;
  // rotate valids so bit 0 is the requester just after rr_ptr, then take the lowest set bit
  always_comb begin
    rot = NREQ'({req_valid, req_valid} >> ({1'b0, rr_ptr} + 1'b1));
    off = '0;
    for (int i = NREQ-1; i >= 0; i--)
      if (rot[i]) off = (IDW+1)'(i);
    sum    = {1'b0, rr_ptr} + 1'b1 + off;
    gnt_id = IDW'(sum >= NQ ? sum - NQ : sum);
    rr_upd = issue;
`ifdef SHIFT_ARB_PRIO_EN
    if (req_valid[0]) begin
      gnt_id = '0;
      rr_upd = 1'b0;
    end
`endif
    req_ready = '0;
    if (issue) req_ready[gnt_id] = 1'b1;
  end
  assign sh_data_in   = issue ? req_data[int'(gnt_id)*BUSWIDTH +: BUSWIDTH] : '0;
  assign sh_shift_val = issue ? req_shift[int'(gnt_id)*SHIFTWIDTH +: SHIFTWIDTH] : '0;
  assign sh_rotation  = issue & req_rotation[gnt_id];
  assign sh_direction = issue & req_direction[gnt_id];
  // credits reserve a FIFO slot at issue time, so a push never finds the FIFO full
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      credits     <= 2'd2;
      rr_ptr      <= IDW'(NREQ-1);
      inflight_v  <= 1'b0;
      inflight_id <= '0;
      fifo_count  <= 2'd0;
      rsp_data    <= '0;
      rsp_id      <= '0;
      data1       <= '0;
      id1         <= '0;
    end else begin
      credits    <= credits - {1'b0, issue} + {1'b0, pop};
      inflight_v <= issue;
      if (issue) inflight_id <= gnt_id;
      if (rr_upd) rr_ptr <= gnt_id;
      fifo_count <= fifo_count + {1'b0, inflight_v} - {1'b0, pop};
      if (pop || (inflight_v && fifo_count == 2'd0)) begin
        rsp_data <= (fifo_count == 2'd2) ? data1 : sh_data_out;
        rsp_id   <= (fifo_count == 2'd2) ? id1 : inflight_id;
      end
      if (inflight_v && fifo_count == (pop ? 2'd2 : 2'd1)) begin
        data1 <= sh_data_out;
        id1   <= inflight_id;
      end
    end
endmodule

// File: tb/tb_shift_req_arbiter.sv
// tb_shift_req_arbiter: scoreboard bench for shift_req_arbiter with a registered barrel shifter model.
module tb_shift_req_arbiter;
  localparam int BW = 32, SW = 5, NR = 4, IW = 2;
  logic            clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0, req_rotation = '0, req_direction = '0, req_ready;
  logic [NR*BW-1:0] req_data = '0;
  logic [NR*SW-1:0] req_shift = '0;
  logic [BW-1:0]   sh_data_in, sh_data_out, rsp_data;
  logic            sh_rotation, sh_direction, rsp_valid, busy;
  logic            rsp_ready = 1'b0;
  logic [SW-1:0]   sh_shift_val;
  logic [IW-1:0]   rsp_id;
  int              errors = 0, checks = 0;
  logic [IW+BW-1:0] sb_q[$];

  always #5 clk = ~clk;

  shift_req_arbiter #(.BUSWIDTH(BW), .SHIFTWIDTH(SW), .NREQ(NR), .IDW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_rotation(req_rotation), .req_direction(req_direction), .req_shift(req_shift),
    .sh_data_in(sh_data_in), .sh_rotation(sh_rotation), .sh_direction(sh_direction),
    .sh_shift_val(sh_shift_val), .sh_data_out(sh_data_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  function automatic logic [BW-1:0] shf(input logic [BW-1:0] d, input logic r, input logic dr, input logic [SW-1:0] a);
    if (r) return dr ? ((d >> a) | (d << (6'd32 - a))) : ((d << a) | (d >> (6'd32 - a)));
    return dr ? (d >> a) : (d << a);
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_data_out <= '0;
    else sh_data_out <= shf(sh_data_in, sh_rotation, sh_direction, sh_shift_val);

  // scoreboard: pop on response acceptance, push on request handshake
  always @(negedge clk) if (rst_n) begin : mon
    logic [IW+BW-1:0] e;
    if (rsp_valid && rsp_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_pop: unexpected response id=%0d data=%h, expected none", rsp_id, rsp_data);
      end else begin
        e = sb_q.pop_front();
        if ({rsp_id, rsp_data} !== e) begin
          errors++;
          $display("FAIL sb_result: got id=%0d data=%h expected id=%0d data=%h", rsp_id, rsp_data, e[IW+BW-1:BW], e[BW-1:0]);
        end
      end
    end
    if (req_ready != '0) begin
      checks++;
      if (!$onehot(req_ready) || (req_ready & ~req_valid) != '0) begin
        errors++;
        $display("FAIL grant_shape: req_ready=%b req_valid=%b, expected one-hot subset", req_ready, req_valid);
      end
      for (int i = 0; i < NR; i++)
        if (req_ready[i] && req_valid[i])
          sb_q.push_back({IW'(i), shf(req_data[i*BW +: BW], req_rotation[i], req_direction[i], req_shift[i*SW +: SW])});
    end
  end

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [BW-1:0] d, input logic r, input logic dr, input logic [SW-1:0] a);
    req_data[i*BW +: BW] = d;
    req_rotation[i] = r;
    req_direction[i] = dr;
    req_shift[i*SW +: SW] = a;
  endtask

  task automatic rand_req(input int i);
    set_req(i, $urandom, 1'($urandom), 1'($urandom), 5'($urandom));
  endtask

  task automatic do_reset;
    req_valid = '0; rsp_ready = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain;
    int n = 0;
    req_valid = '0; rsp_ready = 1'b1;
    while (busy && n < 40) begin cyc; n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy: busy=%b after %0d cycles, expected 0", busy, n); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL drain_sb: %0d results outstanding, expected 0", sb_q.size()); end
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < budget) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL rst_rsp_data: got %h expected 0", rsp_data); end
    checks++; if (rsp_id !== '0) begin errors++; $display("FAIL rst_rsp_id: got %0d expected 0", rsp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single;
    do_reset;
    set_req(0, 32'h8000_0001, 1'b1, 1'b0, 5'd1);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    cyc; req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_t1: rsp_valid=%b busy=%b expected 0 1", rsp_valid, busy); end
    cyc;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0003 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL single_t2: valid=%b data=%h id=%0d expected 1 00000003 0", rsp_valid, rsp_data, rsp_id);
    end
    cyc; drain;
  endtask

  task automatic test_round_robin;
    do_reset;
    for (int i = 0; i < NR; i++) rand_req(i);
    rsp_ready = 1'b1; req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << (k % NR))) begin errors++; $display("FAIL rr_grant: cycle %0d got %b expected %b", k, req_ready, 4'(1 << (k % NR))); end
      cyc;
      rand_req(k % NR);
    end
    drain;
  endtask

  task automatic test_back_to_back;
    int n = 0;
    logic [BW-1:0] held = '0;
    rsp_ready = 1'b0; req_valid = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      rand_req(1);
      @(negedge clk);
      if (req_ready[1]) n++;
      if (k == 3) held = rsp_data;
      if (k == 5) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== held) begin errors++; $display("FAIL stall_hold: valid=%b data=%h expected 1 %h", rsp_valid, rsp_data, held); end
      end
      cyc;
    end
    checks++; if (n != 2) begin errors++; $display("FAIL stall_count: %0d handshakes expected 2", n); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL stall_ready: got %b expected 0000", req_ready); end
    rand_req(1); rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL resume_bypass: got %b expected 0010", req_ready); end
    cyc;
    repeat (3) begin rand_req(1); cyc; end
    drain;
  endtask

  task automatic test_boundary;
    rsp_ready = 1'b1;
    set_req(2, 32'hF000_0000, 1'b0, 1'b1, 5'd31); req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bnd_grant31: got %b expected 0100", req_ready); end
    cyc; req_valid = '0;
    wait_rsp(10);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0001 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL bnd_amt31: valid=%b data=%h id=%0d expected 1 00000001 2", rsp_valid, rsp_data, rsp_id);
    end
    cyc;
    set_req(2, 32'hF000_0000, 1'b0, 1'b1, 5'd0); req_valid = 4'b0100;
    @(negedge clk);
    cyc; req_valid = '0;
    wait_rsp(10);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hF000_0000 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL bnd_amt0: valid=%b data=%h id=%0d expected 1 f0000000 2", rsp_valid, rsp_data, rsp_id);
    end
    cyc; drain;
  endtask

  task automatic test_reset_midop;
    logic c1, c2;
    rsp_ready = 1'b0; rand_req(3); req_valid = 4'b1000;
    @(negedge clk); c1 = req_ready[3]; cyc;
    @(negedge clk); c2 = req_ready[3]; cyc;
    checks++; if (!(c1 && c2)) begin errors++; $display("FAIL mid_setup: handshakes %b%b expected 11", c1, c2); end
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_state: busy=%b rsp_valid=%b expected 1 1", busy, rsp_valid); end
    req_valid = '0; rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy); end
    @(posedge clk); #1;
    sb_q.delete(); rst_n = 1'b1;
    rand_req(1); rand_req(3); req_valid = 4'b1010;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL post_rst_first: got %b expected 0010", req_ready); end
    cyc;
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL post_rst_second: got %b expected 1000", req_ready); end
    cyc;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL post_rst_credits: got %b expected 0000", req_ready); end
    cyc; drain;
  endtask

  task automatic test_prio;
    logic [NR-1:0] exp;
    do_reset;
    rand_req(0); rand_req(3); rsp_ready = 1'b1; req_valid = 4'b1001;
    for (int k = 0; k < 5; k++) begin
`ifdef SHIFT_ARB_PRIO_EN
      exp = 4'b0001;
`else
      exp = (k % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
      @(negedge clk);
      checks++; if (req_ready !== exp) begin errors++; $display("FAIL prio_grant: cycle %0d got %b expected %b", k, req_ready, exp); end
      cyc;
    end
    req_valid = 4'b1000;
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL prio_drop: got %b expected 1000", req_ready); end
    cyc; drain;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_back_to_back;
    test_boundary;
    test_reset_midop;
    test_prio;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
